mac_dot_seq: RTL and testbench

Sequencer that drives the MAC unit (`mac_top`) through its start/ready/clear handshake to compute an N-element signed dot product. It accepts a length command and a stream of signed operand pairs, and clears the accumulator. It issues one multiply-accumulate per pair, waits for the MAC to complete each one, and returns the final 40-bit accumulator value on a result handshake. It sits between the operand source and `mac_top` and replaces bench-style manual sequencing in the datapath.

---
 rtl/mac_dot_seq.sv | 149 ++++++++++++++
 tb/tb_mac_dot_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: walks mac_top through clear/start/ready for N operand pairs
// and returns the final accumulator on a result handshake, with a per-op watchdog.
module mac_dot_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40,
   parameter int MAX_LEN    = 256,
   parameter int TIMEOUT    = 1024,
   localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [LEN_W-1:0]      cmd_len,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic                  mac_start,
   output logic                  mac_clr_acc,
   output logic [DATA_WIDTH-1:0] mac_a,
   output logic [DATA_WIDTH-1:0] mac_b,
   input  logic                  mac_ready,
   input  logic [ACC_WIDTH-1:0]  mac_acc,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ACC_WIDTH-1:0]  res_data,
   output logic                  res_err,
   output logic                  busy
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FETCH, S_ISSUE, S_WAIT, S_SETTLE, S_DONE
   } state_t;

   typedef struct packed {
      logic                 err;
      logic [ACC_WIDTH-1:0] data;
   } res_t;

   state_t            state, state_nx;
   logic [LEN_W-1:0]  remaining;
   logic [WD_W-1:0]   wdog;
   res_t              res_q;
   logic [LEN_W-1:0]  len_clamped;
   logic              wd_expired;
   logic              last_pair;

   assign len_clamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
   assign wd_expired  = (wdog == WD_W'(TIMEOUT - 1));
   assign last_pair   = (remaining == LEN_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Handshake and MAC strobes decode straight from the state register, so an
   // async reset drops them in the same instant the FSM returns to IDLE.
   always_comb begin
      state_nx    = state;
      cmd_ready   = 1'b0;
      op_ready    = 1'b0;
      mac_start   = 1'b0;
      mac_clr_acc = 1'b0;
      res_valid   = 1'b0;
      unique case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nx = S_CLEAR;
         end
         S_CLEAR: begin
            mac_clr_acc = 1'b1;
            state_nx    = (remaining == '0) ? S_DONE : S_FETCH;
         end
         S_FETCH: begin
            op_ready = 1'b1;
            if (op_valid) state_nx = S_ISSUE;
         end
         S_ISSUE: begin
            mac_start = 1'b1;
            state_nx  = S_WAIT;
         end
         S_WAIT: begin
            if (mac_ready)       state_nx = S_SETTLE;
            else if (wd_expired) state_nx = S_DONE;
         end
         S_SETTLE: state_nx = last_pair ? S_DONE : S_FETCH;
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // SETTLE exists because mac_acc only reflects the new product one cycle
   // after mac_ready is first seen high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= '0;
         wdog      <= '0;
         mac_a     <= '0;
         mac_b     <= '0;
         res_q     <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cmd_valid) remaining <= len_clamped;
            end
            S_CLEAR: begin
               if (remaining == '0) res_q <= '0;
            end
            S_FETCH: begin
               if (op_valid) begin
                  mac_a <= op_a;
                  mac_b <= op_b;
               end
            end
            S_ISSUE: wdog <= '0;
            S_WAIT: begin
               if (!mac_ready) begin
                  if (wd_expired) begin
                     res_q.data <= mac_acc;
                     res_q.err  <= 1'b1;
                  end else begin
                     wdog <= wdog + 1'b1;
                  end
               end
            end
            S_SETTLE: begin
               remaining <= remaining - 1'b1;
               if (last_pair) begin
                  res_q.data <= mac_acc;
                  res_q.err  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign res_data = res_q.data;
   assign res_err  = res_q.err;
   assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: behavioural mac_top with programmable latency, random
// operand streams, and a plain-arithmetic dot-product reference.
module tb_mac_dot_seq;
   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [8:0]  cmd_len = '0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [15:0] op_a = '0, op_b = '0;
   logic        mac_start, mac_clr_acc;
   logic [15:0] mac_a, mac_b;
   logic        mac_ready;
   logic [39:0] mac_acc;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [39:0] res_data;
   logic        res_err, busy;

   always #5 clk = ~clk;

   mac_dot_seq #(.DATA_WIDTH(16), .ACC_WIDTH(40), .MAX_LEN(256), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .mac_start(mac_start), .mac_clr_acc(mac_clr_acc), .mac_a(mac_a), .mac_b(mac_b),
      .mac_ready(mac_ready), .mac_acc(mac_acc),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_err(res_err), .busy(busy)
   );

   // mac_top stand-in: ready drops after start, returns after lat WAIT cycles,
   // and the sum lands one cycle after ready rises.
   int          lat = 4;
   bit          stuck = 1'b0;
   logic        m_rdy = 1'b1;
   int          m_cnt = 0;
   bit          m_pend = 1'b0;
   logic [39:0] m_acc = '0;
   longint      m_prod = 0;

   assign mac_ready = m_rdy;
   assign mac_acc   = m_acc;

   always @(posedge clk) begin
      if (mac_clr_acc) m_acc <= '0;
      if (m_pend) begin
         m_acc  <= m_acc + m_prod[39:0];
         m_pend <= 1'b0;
      end
      if (mac_start) begin
         m_rdy  <= 1'b0;
         m_cnt  <= lat - 1;
         m_prod <= longint'($signed(mac_a)) * longint'($signed(mac_b));
      end else if (!m_rdy && !stuck) begin
         if (m_cnt <= 1) begin
            m_rdy  <= 1'b1;
            m_pend <= 1'b1;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   int   cyc = 0;
   int   st_q[$];
   int   n_clr = 0;
   int   rv_cyc = -1;
   logic rv_d = 1'b0;

   always @(posedge clk) begin
      if (mac_start) st_q.push_back(cyc);
      if (mac_clr_acc) n_clr <= n_clr + 1;
      if (res_valid && !rv_d) rv_cyc <= cyc;
      rv_d <= res_valid;
      cyc  <= cyc + 1;
   end

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint rnd16();
      logic signed [15:0] v;
      v = 16'($urandom);
      return longint'(v);
   endfunction

   longint pa[$], pb[$];

   task automatic wait_cmd_ready();
      int k = 0;
      while (!cmd_ready && k < 5000) begin @(negedge clk); k++; end
   endtask

   task automatic wait_res_valid();
      int k = 0;
      while (!res_valid && k < 5000) begin @(negedge clk); k++; end
   endtask

   task automatic feed(input longint a, input longint b, input string tag);
      int k = 0;
      longint ta, tb;
      ta = a; tb = b;
      op_valid = 1'b1; op_a = ta[15:0]; op_b = tb[15:0];
      while (!op_ready && k < 5000) begin @(negedge clk); k++; end
      chk({tag, "/op_hs"}, op_ready, 1);
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   // Run one command over pa/pb; expected sum comes from plain arithmetic.
   task automatic do_dot(input string tag, input int len, input int gap, input int rdly);
      int neff, s0, c0;
      longint sum;
      logic [39:0] exp, hold;
      neff = (len > 256) ? 256 : len;
      sum = 0;
      for (int i = 0; i < neff; i++) sum += pa[i] * pb[i];
      exp = sum[39:0];
      s0 = st_q.size(); c0 = n_clr;
      wait_cmd_ready();
      chk({tag, "/cmd_rdy"}, cmd_ready, 1);
      cmd_valid = 1'b1; cmd_len = len[8:0];
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({tag, "/clr_t1"}, mac_clr_acc, 1);
      @(negedge clk);
      if (neff == 0) begin
         chk({tag, "/done_t2"}, res_valid, 1);
         chk({tag, "/zero_data"}, res_data, 0);
      end else begin
         chk({tag, "/fetch_t2"}, op_ready, 1);
      end
      for (int i = 0; i < neff; i++) begin
         repeat (gap) @(negedge clk);
         feed(pa[i], pb[i], tag);
      end
      wait_res_valid();
      chk({tag, "/res_valid"}, res_valid, 1);
      chk({tag, "/res_data"}, res_data, exp);
      chk({tag, "/res_err"}, res_err, 0);
      hold = res_data;
      cmd_valid = (rdly > 0);
      cmd_len = 9'd1;
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk);
         chk({tag, "/hold_data"}, res_data, hold);
         chk({tag, "/hold_valid"}, res_valid, 1);
         chk({tag, "/hold_cmd_rdy"}, cmd_ready, 0);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, "/post_valid"}, res_valid, 0);
      chk({tag, "/post_cmd_rdy"}, cmd_ready, 1);
      chk({tag, "/starts"}, st_q.size() - s0, neff);
      chk({tag, "/clears"}, n_clr - c0, 1);
      if (neff > 0)
         chk({tag, "/done_lat"}, rv_cyc - st_q[st_q.size()-1], lat + 2);
      if (gap == 0 && neff >= 2)
         chk({tag, "/pair_lat"}, st_q[s0+1] - st_q[s0], lat + 3);
      pa.delete(); pb.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int s0;
      logic [39:0] cexp;
      repeat (3) @(negedge clk);
      chk("rst/cmd_ready", cmd_ready, 1);
      chk("rst/busy", busy, 0);
      chk("rst/op_ready", op_ready, 0);
      chk("rst/res_valid", res_valid, 0);
      chk("rst/res_data", res_data, 0);
      chk("rst/res_err", res_err, 0);
      chk("rst/strobes", {mac_start, mac_clr_acc}, 0);
      chk("rst/mac_ab", {mac_a, mac_b}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      lat = 4;
      pa = '{10, 2, 100}; pb = '{5, -3, 10};
      do_dot("dot3", 3, 0, 0);
      chk("dot3/const", res_data, 40'd1044);

      lat = 3;
      pa = '{-32768, -32768}; pb = '{-32768, -32768};
      do_dot("ext2", 2, 0, 1);
      chk("ext2/const", res_data, 40'd2147483648);
      pa = '{-32768}; pb = '{32767};
      do_dot("ext1", 1, 0, 0);
      cexp = -40'sd1073709056;
      chk("ext1/const", res_data, cexp);

      do_dot("zero", 0, 0, 2);

      lat = 5;
      for (int i = 0; i < 4; i++) begin pa.push_back(rnd16()); pb.push_back(rnd16()); end
      do_dot("bp", 4, 3, 5);

      for (int r = 0; r < 6; r++) begin
         int n;
         lat = 2 + int'($urandom_range(6));
         n = 1 + int'($urandom_range(5));
         for (int i = 0; i < n; i++) begin pa.push_back(rnd16()); pb.push_back(rnd16()); end
         do_dot($sformatf("rnd%0d", r), n, int'($urandom_range(3)), int'($urandom_range(4)));
      end

      lat = 2;
      for (int i = 0; i < 256; i++) begin pa.push_back(rnd16()); pb.push_back(rnd16()); end
      do_dot("clamp", 300, 0, 0);

      // Timeout: first pair completes, second never returns ready.
      lat = 4;
      wait_cmd_ready();
      cmd_valid = 1'b1; cmd_len = 9'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      s0 = st_q.size();
      feed(123, -45, "tmo");
      feed(7, 7, "tmo");
      stuck = 1'b1;
      wait_res_valid();
      chk("tmo/res_valid", res_valid, 1);
      chk("tmo/res_err", res_err, 1);
      cexp = -40'sd5535;
      chk("tmo/partial", res_data, cexp);
      chk("tmo/op_ready", op_ready, 0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("tmo/idle", cmd_ready, 1);
      chk("tmo/busy", busy, 0);
      chk("tmo/starts", st_q.size() - s0, 2);
      chk("tmo/lat", rv_cyc - st_q[st_q.size()-1], TMO + 1);
      stuck = 1'b0;

      // Reset while the second pair is in WAIT.
      lat = 6;
      wait_cmd_ready();
      cmd_valid = 1'b1; cmd_len = 9'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      feed(1, 2, "rstw");
      feed(3, 4, "rstw");
      repeat (2) @(negedge clk);
      chk("rstw/in_wait", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rstw/cmd_ready", cmd_ready, 1);
      chk("rstw/busy", busy, 0);
      chk("rstw/strobes", {mac_start, mac_clr_acc, op_ready, res_valid}, 0);
      chk("rstw/mac_ab", {mac_a, mac_b}, 0);
      chk("rstw/res", {res_err, res_data}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("rstw/no_result", res_valid, 0);
      pa = '{7}; pb = '{6};
      do_dot("post_rst", 1, 0, 0);
      chk("post_rst/const", res_data, 40'd42);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
